dram_ctrl: RTL and testbench
============================

DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter T_RP, default 5, precharge-to-activate wait in dram_clk cycles (range 1..15).
REQ-002 SHALL have parameter T_RCD, default 5, activate-to-CAS wait in cycles (range 1..15).
REQ-003 SHALL have parameter T_WR, default 5, write-CAS-to-done wait in cycles (range 1..15).
REQ-004 SHALL have one clock and one reset: dram_clk in 1 (single clock; all logic on its rising edge); dram_rst_n in 1 (asynchronous, active-low reset).
REQ-005 SHALL have ports: req_valid in 1 (request present); req_ready out 1 (request accepted when both high); req_write in 1 (1 = write); req_addr in 21 (word address; row = [20:10], col = [9:0]); req_wdata in 32; req_wstrb in 4 (byte enables, active-high).
REQ-006 SHALL have ports: rsp_valid out 1 (one-cycle completion pulse); rsp_rdata out 32 (read data, 0 for writes).
REQ-007 SHALL have DRAM pins: DRAM_CSn out 1; DRAM_RASn out 1; DRAM_CASn out 1; DRAM_WEn out 4 (per-byte, active-low); DRAM_A out 11; DRAM_D out 32; DRAM_Q in 32; DRAM_valid in 1.

Function
REQ-008 SHALL implement states IDLE, PRE, TRP, ACT, TRCD, RD, RDWAIT, WR, TWR; every DRAM command lasts exactly one cycle.
REQ-009 SHALL drive req_ready = 1 only in IDLE; accept at most one request per pass through IDLE and latch addr/wdata/wstrb/write on acceptance.
REQ-010 SHALL route an accepted request from IDLE as follows: no row open -> ACT; row open, different row -> PRE; row open, same row -> RD or WR.
REQ-011 SHALL encode PRE as CSn=0, RASn=0, CASn=1, WEn=4'h0; encode ACT as RASn=0, CASn=1, WEn=4'hF, A=row.
REQ-012 SHALL encode RD as RASn=1, CASn=0, WEn=4'hF, A={1'b0,col}; encode WR as RASn=1, CASn=0, WEn=~wstrb, A={1'b0,col}, D=wdata.
REQ-013 SHALL drive CSn=0 in every non-IDLE state; in wait states hold RASn=CASn=1 and WEn=4'hF.
REQ-014 SHALL stay T_RP cycles in TRP, T_RCD cycles in TRCD and T_WR cycles in TWR, counted from the cycle after the command.
REQ-015 SHALL stay in RDWAIT until DRAM_valid=1; on that cycle SHALL register DRAM_Q into rsp_rdata and pulse rsp_valid in the next cycle, with IDLE entered in that same next cycle.
REQ-016 SHALL pulse rsp_valid with rsp_rdata=0 in the cycle after TWR expires; SHALL never assert rsp_valid for two consecutive cycles.
REQ-017 SHALL ignore a DRAM_valid pulse outside RDWAIT.
REQ-018 SHALL treat req_wstrb=4'h0 writes as full sequences issuing WEn=4'hF at CAS, followed by a normal ack.

Reset
REQ-019 SHALL on dram_rst_n=0, immediately and mid-operation, enter IDLE, clear row-open flag and counters, and drive CSn=RASn=CASn=1, WEn=4'hF, A=0, D=0, rsp_valid=0, rsp_rdata=0; req_ready=1 after release.

Configuration
REQ-020 SHALL use macro DRAM_OPEN_PAGE_EN: when defined, the row stays open after access (REQ-010 hit/miss rules); when undefined, every access passes through PRE+TRP after RD/WR completes and the row-open flag is always 0 at IDLE.

Structure
REQ-021 SHALL place the state enum, command-encoding constants and default timing constants in package dram_ctrl_pkg.
REQ-022 SHALL use one sub-module dram_timer (load value, count down, done flag) shared by TRP/TRCD/TWR.

Verification
REQ-023 SHALL cover read after reset: addr 0x10005 -> ACT A=0x040, T_RCD wait, RD A=0x005; DRAM_valid with Q=0xDEADBEEF -> rsp_valid pulse, rsp_rdata=0xDEADBEEF.
REQ-024 SHALL cover write: addr 0x00003, wdata 0x12345678, wstrb 4'b0101 -> WR cycle WEn=4'b1010, D=0x12345678; ack T_WR+1 cycles later.
REQ-025 SHALL cover row hit with DRAM_OPEN_PAGE_EN: two reads to row 0x040 -> second issues RD with no PRE/ACT.
REQ-026 SHALL cover row miss: row 0x040 then row 0x041 -> PRE, T_RP, ACT A=0x041, RD; without the macro, PRE follows each access.
REQ-027 SHALL cover reset asserted in RDWAIT -> outputs at reset values asynchronously; the next request goes to ACT without PRE.
REQ-028 SHALL cover back-to-back req_valid held high -> one acceptance per IDLE visit, strictly in-order responses.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the single-bank DRAM controller: FSM states,
// pin-level command encodings and default timing values.
package dram_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, PRE, TRP, ACT, TRCD, RD, RDWAIT, WR, TWR
  } state_t;

  localparam int DEF_T_RP  = 5;
  localparam int DEF_T_RCD = 5;
  localparam int DEF_T_WR  = 5;
  localparam int TMR_W     = 4;

  typedef struct packed {
    logic       csn;
    logic       rasn;
    logic       casn;
    logic [3:0] wen;
  } dram_cmd_t;

  localparam dram_cmd_t CMD_DESEL = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_NOP   = '{csn: 1'b0, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_PRE   = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
  localparam dram_cmd_t CMD_ACT   = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_CAS   = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter shared by the precharge, activate and write-recovery waits.
// done is high in the last cycle of a wait of load_val cycles.
module dram_timer
  import dram_ctrl_pkg::*;
(
  input  logic             dram_clk,
  input  logic             dram_rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n)      cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == TMR_W'(1));

endmodule

// File: rtl/dram_ctrl.sv
// Single-request DRAM controller: one outstanding access, open/closed page policy.
// Define DRAM_OPEN_PAGE_EN to keep rows open between accesses; default closes after each.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_WR  = DEF_T_WR
) (
  input  logic        dram_clk,
  input  logic        dram_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [20:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  state_t      state, nxt;
  logic        wr_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        row_open;
  logic [10:0] open_row;
  logic        tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
  logic        rd_done, wr_done;
  state_t      after_access;
  dram_cmd_t   cmd;

`ifdef DRAM_OPEN_PAGE_EN
  localparam state_t AFTER_ACC = IDLE;
  localparam state_t AFTER_TRP = ACT;
`else
  // Closed page: the precharge after an access is the only PRE, so TRP returns home.
  localparam state_t AFTER_ACC = PRE;
  localparam state_t AFTER_TRP = IDLE;
`endif

  assign after_access = AFTER_ACC;
  assign req_ready    = (state == IDLE);
  assign rd_done      = (state == RDWAIT) && DRAM_valid;
  assign wr_done      = (state == TWR) && tmr_done;

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) state <= IDLE;
    else             state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) begin
                 if (!row_open)                      nxt = ACT;
                 else if (open_row != req_addr[20:10]) nxt = PRE;
                 else                                nxt = req_write ? WR : RD;
               end
      PRE:     nxt = TRP;
      TRP:     if (tmr_done) nxt = AFTER_TRP;
      ACT:     nxt = TRCD;
      TRCD:    if (tmr_done) nxt = wr_q ? WR : RD;
      RD:      nxt = RDWAIT;
      RDWAIT:  if (DRAM_valid) nxt = after_access;
      WR:      nxt = TWR;
      TWR:     if (tmr_done) nxt = after_access;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state == IDLE && req_valid) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      row_open <= 1'b0;
      open_row <= '0;
    end else if (state == ACT) begin
      row_open <= 1'b1;
      open_row <= addr_q[20:10];
    end else if (state == PRE) begin
      row_open <= 1'b0;
    end
  end

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rd_done || wr_done;
      if (rd_done)      rsp_rdata <= DRAM_Q;
      else if (wr_done) rsp_rdata <= '0;
    end
  end

  always_comb begin
    tmr_load = 1'b1;
    tmr_val  = '0;
    case (state)
      PRE:     tmr_val = TMR_W'(T_RP);
      ACT:     tmr_val = TMR_W'(T_RCD);
      WR:      tmr_val = TMR_W'(T_WR);
      default: tmr_load = 1'b0;
    endcase
  end

  dram_timer u_timer (
    .dram_clk   (dram_clk),
    .dram_rst_n (dram_rst_n),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .done       (tmr_done)
  );

  always_comb begin
    cmd    = CMD_NOP;
    DRAM_A = '0;
    DRAM_D = '0;
    case (state)
      IDLE: cmd = CMD_DESEL;
      PRE:  cmd = CMD_PRE;
      ACT:  begin cmd = CMD_ACT; DRAM_A = addr_q[20:10]; end
      RD:   begin cmd = CMD_CAS; DRAM_A = {1'b0, addr_q[9:0]}; end
      WR:   begin
              cmd     = CMD_CAS;
              cmd.wen = ~wstrb_q;
              DRAM_A  = {1'b0, addr_q[9:0]};
              DRAM_D  = wdata_q;
            end
      default: cmd = CMD_NOP;
    endcase
  end

  assign DRAM_CSn  = cmd.csn;
  assign DRAM_RASn = cmd.rasn;
  assign DRAM_CASn = cmd.casn;
  assign DRAM_WEn  = cmd.wen;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: directed and random transactions checked against a
// transaction-level model of expected command sequences, timing and responses.
module tb_dram_ctrl;
  localparam int T_RP = 3, T_RCD = 4, T_WR = 2;
`ifdef DRAM_OPEN_PAGE_EN
  localparam bit OPEN = 1'b1;
`else
  localparam bit OPEN = 1'b0;
`endif
  localparam int PRE_K = 0, ACT_K = 1, CAS_K = 2, BAD_K = 3;

  logic        dram_clk = 1'b0, dram_rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [20:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q = '0;
  logic        DRAM_valid = 1'b0;

  int checks = 0, errors = 0;
  bit         m_open = 1'b0;
  logic [10:0] m_row = '0;

  typedef struct {int kind; logic [10:0] a; logic [3:0] wen; logic [31:0] d; int cyc;} cmd_t;

  dram_ctrl #(.T_RP(T_RP), .T_RCD(T_RCD), .T_WR(T_WR)) dut (
    .dram_clk(dram_clk), .dram_rst_n(dram_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
    .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
  );

  always #5 dram_clk = ~dram_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // -1 = no command on the pins this cycle
  function automatic int cur_kind();
    if (DRAM_CSn !== 1'b0 || (DRAM_RASn === 1'b1 && DRAM_CASn === 1'b1)) return -1;
    if (DRAM_RASn === 1'b0 && DRAM_CASn === 1'b1)
      return (DRAM_WEn === 4'h0) ? PRE_K : (DRAM_WEn === 4'hF) ? ACT_K : BAD_K;
    if (DRAM_RASn === 1'b1 && DRAM_CASn === 1'b0) return CAS_K;
    return BAD_K;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csn"}, DRAM_CSn, 1'b1);
    chk({tag, "_rasn"}, DRAM_RASn, 1'b1);
    chk({tag, "_casn"}, DRAM_CASn, 1'b1);
    chk({tag, "_wen"}, DRAM_WEn, 4'hF);
    chk({tag, "_a"}, DRAM_A, 11'h0);
    chk({tag, "_d"}, DRAM_D, 32'h0);
    chk({tag, "_rspv"}, rsp_valid, 1'b0);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
  endtask

  // Starts and ends on a falling edge with the controller idle.
  task automatic run_txn(input bit wr, input logic [20:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] q, input int dly);
    cmd_t exp[$];
    cmd_t obs[$];
    cmd_t c;
    logic [10:0] row;
    bit hit;
    int cyc, k, dv_cyc, cas_cyc, rsp_cyc, rsp_n, idle_cyc, bad, n;
    logic [31:0] rsp_d;
    row = addr[20:10];
    hit = m_open && (m_row == row);
    if (m_open && !hit) begin c = '{PRE_K, 11'h0, 4'h0, 32'h0, 0}; exp.push_back(c); end
    if (!hit) begin c = '{ACT_K, row, 4'hF, 32'h0, 0}; exp.push_back(c); end
    c = '{CAS_K, {1'b0, addr[9:0]}, wr ? ~ws : 4'hF, wr ? wd : 32'h0, 0};
    exp.push_back(c);
    if (!OPEN) begin c = '{PRE_K, 11'h0, 4'h0, 32'h0, 0}; exp.push_back(c); end
    m_open = OPEN;
    m_row  = row;

    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    @(negedge dram_clk);
    req_valid = 1'b0;
    cyc = 0; dv_cyc = -1; cas_cyc = -1; rsp_cyc = -1; rsp_n = 0; idle_cyc = -1; bad = 0;
    rsp_d = 'x;
    while (idle_cyc < 0 && cyc < 300) begin
      DRAM_valid = 1'b0;
      k = cur_kind();
      if (k >= 0) begin
        c = '{k, DRAM_A, DRAM_WEn, DRAM_D, cyc};
        obs.push_back(c);
        if (k == CAS_K) begin
          cas_cyc = cyc;
          if (!wr) dv_cyc = cyc + 1 + dly;
        end
      end
      if (rsp_valid) begin rsp_n++; rsp_cyc = cyc; rsp_d = rsp_rdata; end
      if (rsp_n > 0 && req_ready) idle_cyc = cyc;
      else if (k < 0 && (DRAM_CSn !== 1'b0 || DRAM_WEn !== 4'hF)) bad++;
      // stray data-valid pulses outside the read wait must be ignored
      if (cyc == 0 || k == CAS_K) begin DRAM_valid = 1'b1; DRAM_Q = 32'hBAD0_0000 | cyc; end
      if (cyc == dv_cyc) begin DRAM_valid = 1'b1; DRAM_Q = q; end
      @(negedge dram_clk);
      cyc++;
    end
    DRAM_valid = 1'b0;
    chk("idle_reached", idle_cyc >= 0, 1'b1);
    chk("rsp_single_pulse", rsp_valid, 1'b0);
    chk("ready_in_idle", req_ready, 1'b1);
    chk("cmd_count", obs.size(), exp.size());
    n = (obs.size() < exp.size()) ? obs.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      chk("cmd_kind", obs[i].kind, exp[i].kind);
      if (exp[i].kind != PRE_K) begin
        chk("cmd_addr", obs[i].a, exp[i].a);
        chk("cmd_wen", obs[i].wen, exp[i].wen);
      end
      if (wr && exp[i].kind == CAS_K) chk("wr_data", obs[i].d, exp[i].d);
    end
    for (int i = 0; i + 1 < obs.size(); i++) begin
      if (obs[i].kind == PRE_K) chk("gap_trp", obs[i+1].cyc - obs[i].cyc, T_RP + 1);
      if (obs[i].kind == ACT_K) chk("gap_trcd", obs[i+1].cyc - obs[i].cyc, T_RCD + 1);
    end
    chk("rsp_count", rsp_n, 1);
    chk("rsp_data", rsp_d, wr ? 32'h0 : q);
    chk("rsp_time", rsp_cyc, wr ? cas_cyc + T_WR + 1 : dv_cyc + 1);
    if (obs.size() > 0) chk("last_cmd_time", obs[obs.size()-1].cyc, OPEN ? cas_cyc : rsp_cyc);
    chk("idle_time", idle_cyc, rsp_cyc + (OPEN ? 0 : T_RP + 1));
    chk("wait_state_pins", bad, 0);
  endtask

  initial begin
    int cyc, acc, rsp, k;
    bit dv_next, cur_wr, upd, seen;
    logic [31:0] expq[$];
    bit          b_wr[6];
    logic [20:0] b_addr[6];
    logic [31:0] b_wd[6];

    // reset state
    #3;
    chk_reset_outputs("reset_init");
    @(negedge dram_clk);
    dram_rst_n = 1'b1;
    @(negedge dram_clk);
    chk("ready_after_reset", req_ready, 1'b1);

    // read after reset
    run_txn(1'b0, 21'h10005, 32'h0, 4'h0, 32'hDEADBEEF, 2);

    // reset in the read wait; row must be forgotten
    req_valid = 1'b1; req_write = 1'b0; req_addr = {11'h040, 10'h011};
    @(negedge dram_clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (cur_kind() == CAS_K) seen = 1'b1;
      else @(negedge dram_clk);
    end
    chk("rst_cas_seen", seen, 1'b1);
    @(negedge dram_clk);
    #2 dram_rst_n = 1'b0;
    #1 chk_reset_outputs("reset_midop");
    @(negedge dram_clk);
    dram_rst_n = 1'b1;
    m_open = 1'b0;
    @(negedge dram_clk);
    run_txn(1'b0, 21'h10005, 32'h0, 4'h0, 32'h0BADF00D, 0);

    // writes, including all byte enables off
    run_txn(1'b1, 21'h00003, 32'h12345678, 4'b0101, 32'h0, 0);
    run_txn(1'b1, 21'h00007, 32'hCAFEF00D, 4'h0, 32'h0, 0);
    // row hit then row miss
    run_txn(1'b0, {11'h040, 10'h001}, 32'h0, 4'h0, 32'h11111111, 1);
    run_txn(1'b0, {11'h040, 10'h3FF}, 32'h0, 4'h0, 32'h22222222, 0);
    run_txn(1'b0, {11'h041, 10'h002}, 32'h0, 4'h0, 32'h33333333, 3);

    for (int t = 0; t < 20; t++)
      run_txn($urandom_range(0, 1) == 1, {11'h040 + 11'($urandom_range(0, 3)), 10'($urandom)},
              $urandom, 4'($urandom), $urandom, $urandom_range(0, 4));

    // back-to-back with req_valid held high
    for (int i = 0; i < 6; i++) begin
      b_wr[i]   = (i % 3) == 1;
      b_addr[i] = {11'h040 + 11'($urandom_range(0, 1)), 10'($urandom)};
      b_wd[i]   = $urandom;
    end
    acc = 0; rsp = 0; dv_next = 0; cur_wr = 0; upd = 0;
    req_valid = 1'b1; req_write = b_wr[0]; req_addr = b_addr[0];
    req_wdata = b_wd[0]; req_wstrb = 4'hF;
    cyc = 0;
    while (cyc < 2000 && rsp < 6) begin
      DRAM_valid = 1'b0;
      if (dv_next) begin DRAM_valid = 1'b1; DRAM_Q = 32'hA500_0000 | (acc - 1); dv_next = 0; end
      if (upd) begin
        if (acc < 6) begin
          req_write = b_wr[acc]; req_addr = b_addr[acc]; req_wdata = b_wd[acc];
        end else req_valid = 1'b0;
        upd = 0;
      end
      if (rsp_valid) begin
        if (expq.size() > 0) chk("b2b_rdata", rsp_rdata, expq.pop_front());
        else chk("b2b_unexpected_rsp", rsp_valid, 1'b0);
        rsp++;
      end
      k = cur_kind();
      if (k == CAS_K && !cur_wr) dv_next = 1;
      if (req_valid && req_ready) begin
        chk("b2b_one_outstanding", acc, rsp);
        expq.push_back(b_wr[acc] ? 32'h0 : (32'hA500_0000 | acc));
        cur_wr = b_wr[acc];
        acc++;
        upd = 1;
      end
      @(negedge dram_clk);
      cyc++;
    end
    DRAM_valid = 1'b0;
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 6);
    chk("b2b_responses", rsp, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
